// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte handshake between the UART receiver and its consumer
interface uart_rx_if;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_ack;

    modport master (
        output data_out,
        output rx_valid,
        input  rx_ack
    );

    modport slave (
        input  data_out,
        input  rx_valid,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, oversampled, mid-bit sampling, valid/ack byte output
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stb_os,
    input  logic       serial_in,
    uart_rx_if.master  rx_if,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_os_cnt;
    logic [CW-1:0]   w_os_cnt_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_rx_s;
    logic            w_byte_done;
    logic            w_frame_err;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_os_cnt    <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], serial_in};
            r_state     <= w_state_nxt;
            r_os_cnt    <= w_os_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err;
            // A new byte wins over an ack; an ack in the same cycle only suppresses overrun.
            if (w_byte_done) begin
                r_data    <= r_shift;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~rx_if.rx_ack;
            end else if (rx_if.rx_ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_os_cnt_nxt  = r_os_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_done   = 1'b0;
        w_frame_err   = 1'b0;
        if (stb_os) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt  = S_START;
                        w_os_cnt_nxt = '0;
                    end
                end
                S_START: begin
                    if (r_os_cnt == HALF_LAST) begin
                        w_os_cnt_nxt = '0;
                        if (w_rx_s) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt   = S_DATA;
                            w_bit_idx_nxt = '0;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_os_cnt == FULL_LAST) begin
                        w_shift_nxt[r_bit_idx] = w_rx_s;
                        w_os_cnt_nxt           = '0;
                        w_bit_idx_nxt          = r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_os_cnt == FULL_LAST) begin
                        w_os_cnt_nxt = '0;
                        w_state_nxt  = S_IDLE;
                        w_byte_done  = w_rx_s;
                        w_frame_err  = ~w_rx_s;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + CW'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign rx_if.data_out = r_data;
    assign rx_if.rx_valid = r_valid;
    assign rx_busy        = (r_state != S_IDLE);
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;
    logic clk;
    logic rst_n;
    logic stb_os;
    logic serial_in;
    logic rx_busy;
    logic frame_err;
    logic overrun;

    uart_rx_if u_if ();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stb_os    (stb_os),
        .serial_in (serial_in),
        .rx_if     (u_if),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int checks   = 0;
    int failures = 0;
    int ferr_cnt = 0;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_overrun;
    int         m_ferr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe every 4 clocks, changing away from clock edges; high across posedges at 35 mod 40.
    initial begin
        stb_os = 1'b0;
        #2;
        forever begin
            #30 stb_os = 1'b1;
            #10 stb_os = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frames start 25 time units before a strobe edge so the stop sample lands at a known posedge.
    task automatic align();
        @(negedge clk);
        while (($time % 40) != 10) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"},    32'(u_if.data_out), 32'(m_data));
        check({tag, "_valid"},   32'(u_if.rx_valid), 32'(m_valid));
        check({tag, "_overrun"}, 32'(overrun),       32'(m_overrun));
        check({tag, "_ferr"},    32'(ferr_cnt),      32'(m_ferr));
        check({tag, "_busy"},    32'(rx_busy),       32'(0));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic ack_at_done);
        align();
        serial_in = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            wait_clks(64);
        end
        serial_in = stop_ok;
        if (ack_at_done) begin
            wait_clks(34);
            u_if.rx_ack = 1'b1;
            wait_clks(1);
            u_if.rx_ack = 1'b0;
            wait_clks(29);
        end else begin
            wait_clks(64);
        end
        serial_in = 1'b1;
        wait_clks(64);
        if (stop_ok) begin
            m_overrun = m_valid && !ack_at_done;
            m_data    = b;
            m_valid   = 1'b1;
        end else begin
            m_ferr++;
        end
    endtask

    task automatic ack_pulse();
        wait_clks(1);
        u_if.rx_ack = 1'b1;
        wait_clks(1);
        u_if.rx_ack = 1'b0;
        wait_clks(2);
        if (m_valid) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] part;
        logic       rstop;
        logic       rack;

        rst_n       = 1'b0;
        serial_in   = 1'b1;
        u_if.rx_ack = 1'b0;
        m_data      = 8'h00;
        m_valid     = 1'b0;
        m_overrun   = 1'b0;
        m_ferr      = 0;
        wait_clks(4);
        check_all("reset");
        rst_n = 1'b1;
        wait_clks(8);

        send_frame(8'hA5, 1'b1, 1'b0);
        check_all("t1_a5");
        ack_pulse();
        check_all("t1_ack");

        align();
        serial_in = 1'b0;
        wait_clks(10);
        check("t2_busy_in_start", 32'(rx_busy), 32'(1));
        wait_clks(6);
        serial_in = 1'b1;
        wait_clks(50);
        check_all("t2_glitch");

        send_frame(8'h3C, 1'b0, 1'b0);
        check_all("t3_bad_stop");

        send_frame(8'h11, 1'b1, 1'b0);
        check_all("t4_first");
        send_frame(8'h22, 1'b1, 1'b0);
        check_all("t4_overrun");
        ack_pulse();
        check_all("t4_ack");

        send_frame(8'h44, 1'b1, 1'b0);
        check_all("t5_pre");
        send_frame(8'h55, 1'b1, 1'b1);
        check_all("t5_ack_same_clk");

        part = 8'($urandom);
        align();
        serial_in = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 4; i++) begin
            serial_in = part[i];
            wait_clks(64);
        end
        rst_n     = 1'b0;
        serial_in = 1'b1;
        wait_clks(3);
        rst_n     = 1'b1;
        m_data    = 8'h00;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        wait_clks(2);
        check_all("t6_reset");
        wait_clks(60);
        send_frame(8'h81, 1'b1, 1'b0);
        check_all("t6_after");

        for (int n = 0; n < 12; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rack  = ($urandom_range(0, 2) == 0);
            send_frame(rb, rstop, rack);
            check_all($sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                check_all($sformatf("rand%0d_ack", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
